// File: rtl/calc_alu_sequencer.sv
// Multi-cycle add/sub/multiply sequencer for the 16-bit signed calculator.
// Every arithmetic step (magnitudes, add/sub, shift-add, sign fix) goes through one shared adder.
module calc_alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_error,
  output logic             busy
);

  localparam int AW = 2 * WIDTH;
  localparam logic [AW-1:0] POS_LIMIT = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] NEG_LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ADDSUB,
    MUL,
    SIGNFIX,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             neg_q;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [WIDTH-1:0] iter;

  logic [AW-1:0]    add_x;
  logic [AW-1:0]    add_y;
  logic             add_cin;
  logic [AW-1:0]    add_sum;
  logic [WIDTH-1:0] res_lo;
  logic             addsub_ovf;
  logic             mul_ovf;
  logic             accept;

  assign accept = (state == IDLE) && req_valid;

  // Operand steering for the single adder. In IDLE the two halves negate |a| and |b|
  // at once: the low half never carries out when b is negative (b != 0), so they stay independent.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state)
      IDLE: begin
        add_x   = {req_a ^ {WIDTH{req_a[WIDTH-1]}}, req_b ^ {WIDTH{req_b[WIDTH-1]}}};
        add_y   = {{(WIDTH-1){1'b0}}, req_a[WIDTH-1], {WIDTH{1'b0}}};
        add_cin = req_b[WIDTH-1];
      end
      ADDSUB: begin
        add_x   = {{WIDTH{1'b0}}, a_q};
        add_y   = {{WIDTH{1'b0}}, sub_q ? ~b_q : b_q};
        add_cin = sub_q;
      end
      MUL: begin
        add_x = acc;
        add_y = b_q[0] ? mcand : '0;
      end
      SIGNFIX: begin
        add_x   = neg_q ? ~acc : acc;
        add_cin = neg_q;
      end
      default: ;
    endcase
  end

  assign add_sum = add_x + add_y + {{(AW-1){1'b0}}, add_cin};
  assign res_lo  = add_sum[WIDTH-1:0];

  always_comb begin
    if (sub_q)
      addsub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_lo[WIDTH-1] != a_q[WIDTH-1]);
    else
      addsub_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_lo[WIDTH-1] != a_q[WIDTH-1]);
  end

  assign mul_ovf = neg_q ? (acc > NEG_LIMIT) : (acc > POS_LIMIT);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            2'b00, 2'b01: state_next = ADDSUB;
            2'b10:        state_next = MUL;
            default:      state_next = DONE;
          endcase
        end
      end
      ADDSUB:  state_next = DONE;
      MUL:     if (iter[WIDTH-1]) state_next = SIGNFIX;
      SIGNFIX: state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply walks magB LSB first while the multiplicand shifts left; iter is a one-hot step marker.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      neg_q        <= 1'b0;
      acc          <= '0;
      mcand        <= '0;
      iter         <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_error    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sub_q        <= req_op[0];
            neg_q        <= req_a[WIDTH-1] ^ req_b[WIDTH-1];
            acc          <= '0;
            iter         <= {{(WIDTH-1){1'b0}}, 1'b1};
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
            if (req_op == 2'b10) begin
              a_q   <= add_sum[AW-1:WIDTH];
              b_q   <= add_sum[WIDTH-1:0];
              mcand <= {{WIDTH{1'b0}}, add_sum[AW-1:WIDTH]};
            end else begin
              a_q   <= req_a;
              b_q   <= req_b;
              mcand <= '0;
            end
            if (req_op == 2'b11) begin
              rsp_result <= '0;
              rsp_error  <= 1'b1;
            end
          end
        end
        ADDSUB: begin
          rsp_result   <= res_lo;
          rsp_overflow <= addsub_ovf;
        end
        MUL: begin
          acc   <= add_sum;
          mcand <= mcand << 1;
          b_q   <= b_q >> 1;
          iter  <= iter << 1;
        end
        SIGNFIX: begin
          rsp_result   <= res_lo;
          rsp_overflow <= mul_ovf;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed self-checking bench for calc_alu_sequencer: add/sub/mul/illegal ops,
// backpressure, input capture and mid-operation reset.
module tb_calc_alu_sequencer;

  logic        clk;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_error;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  calc_alu_sequencer #(.WIDTH(16)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_error    (rsp_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request at a negedge and returns the number of edges after E0 until rsp_valid.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                               input bit scramble, output int lat);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (scramble) begin
        req_a  = 16'($urandom);
        req_b  = 16'($urandom);
        req_op = 2'($urandom);
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit scramble, input int exp_lat, input logic [15:0] exp_res,
                       input logic exp_ovf, input logic exp_err);
    int lat;
    checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    applyStimulus(op, a, b, scramble, lat);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, ".result"}, 32'(rsp_result), 32'(exp_res));
    checkOutput({tag, ".overflow"}, 32'(rsp_overflow), 32'(exp_ovf));
    checkOutput({tag, ".error"}, 32'(rsp_error), 32'(exp_err));
    @(negedge clk);
    checkOutput({tag, ".idle_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    nRST      = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_a     = 16'd5;
    req_b     = 16'd5;
    rsp_ready = 1'b1;

    // Reset state, with a request offered while in reset
    repeat (3) @(negedge clk);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.result", 32'(rsp_result), 32'd0);
    checkOutput("reset.overflow", 32'(rsp_overflow), 32'd0);
    checkOutput("reset.error", 32'(rsp_error), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    nRST = 1'b1;
    @(negedge clk);
    checkOutput("post_reset.busy", 32'(busy), 32'd0);

    runOp("add_3_4", 2'b00, 16'd3, 16'd4, 1'b0, 1, 16'd7, 1'b0, 1'b0);
    runOp("sub_5_4", 2'b01, 16'd5, 16'd4, 1'b0, 1, 16'd1, 1'b0, 1'b0);
    runOp("sub_m5_4", 2'b01, 16'hFFFB, 16'd4, 1'b0, 1, 16'hFFF7, 1'b0, 1'b0);
    runOp("add_max_1", 2'b00, 16'h7FFF, 16'd1, 1'b0, 1, 16'h8000, 1'b1, 1'b0);
    runOp("sub_min_1", 2'b01, 16'h8000, 16'd1, 1'b0, 1, 16'h7FFF, 1'b1, 1'b0);

    runOp("mul_m3_m4", 2'b10, 16'hFFFD, 16'hFFFC, 1'b0, 17, 16'd12, 1'b0, 1'b0);
    runOp("mul_35_45", 2'b10, 16'd35, 16'd45, 1'b0, 17, 16'd1575, 1'b0, 1'b0);
    runOp("mul_300_200", 2'b10, 16'd300, 16'd200, 1'b0, 17, 16'hEA60, 1'b1, 1'b0);
    runOp("mul_min_1", 2'b10, 16'h8000, 16'd1, 1'b0, 17, 16'h8000, 1'b0, 1'b0);
    runOp("mul_min_m1", 2'b10, 16'h8000, 16'hFFFF, 1'b0, 17, 16'h8000, 1'b1, 1'b0);
    runOp("mul_0_m7", 2'b10, 16'd0, 16'hFFF9, 1'b0, 17, 16'd0, 1'b0, 1'b0);
    runOp("mul_m7_5", 2'b10, 16'hFFF9, 16'd5, 1'b0, 17, 16'hFFDD, 1'b0, 1'b0);

    runOp("illegal", 2'b11, 16'd9, 16'd9, 1'b0, 0, 16'd0, 1'b0, 1'b1);

    runOp("capture_12_12", 2'b10, 16'd12, 16'd12, 1'b1, 17, 16'd144, 1'b0, 1'b0);

    // Backpressure: hold the response for 5 cycles
    rsp_ready = 1'b0;
    applyStimulus(2'b10, 16'd7, 16'd6, 1'b0, lat);
    checkOutput("bp.latency", 32'(lat), 32'd17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp.hold_result", 32'(rsp_result), 32'd42);
      checkOutput("bp.hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp.hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp.release_busy", 32'(busy), 32'd0);
    runOp("bp.next_1_1", 2'b00, 16'd1, 16'd1, 1'b0, 1, 16'd2, 1'b0, 1'b0);

    // Reset in the middle of a 100*100 multiply, right after E8
    req_op    = 2'b10;
    req_a     = 16'd100;
    req_b     = 16'd100;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    nRST      = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b00;
    #1;
    checkOutput("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst.result", 32'(rsp_result), 32'd0);
    checkOutput("midrst.overflow", 32'(rsp_overflow), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkOutput("midrst.req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    nRST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("midrst.no_rsp", 32'(rsp_valid), 32'd0);
    end
    runOp("midrst.add_2_2", 2'b00, 16'd2, 16'd2, 1'b0, 1, 16'd4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
